// File: rtl/uart_bus_arbiter.sv
// rtl/uart_bus_arbiter.sv - round-robin arbiter sharing the UART AHB-style slave port between N requesters
module uart_bus_arbiter #(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  req_write,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]  gnt,
  output logic [N-1:0]  done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          hsel,
  output logic          hwrite,
  output logic [AW-1:0] haddr,
  output logic [DW-1:0] hwdata,
  input  logic          hready,
  input  logic          hresp,
  input  logic [DW-1:0] hrdata
);

  localparam int IW = $clog2(N);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] idx;
  logic          lat_write;
  logic [DW-1:0] lat_wdata;
  logic [CW-1:0] cnt;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          pick_write;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;

  // First asserted request at or after last+1, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last;
    for (int k = 1; k <= N; k++) begin
      if (!pick_valid && req[(int'(last) + k) % N]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(last) + k) % N);
      end
    end
    pick_write = req_write[pick_idx];
    pick_addr  = req_addr[int'(pick_idx) * AW +: AW];
    pick_wdata = req_wdata[int'(pick_idx) * DW +: DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IW'(N - 1);
      idx       <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      hsel      <= 1'b0;
      hwrite    <= 1'b0;
      haddr     <= '0;
      hwdata    <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state         <= ADDR;
            idx           <= pick_idx;
            last          <= pick_idx;
            lat_write     <= pick_write;
            lat_wdata     <= pick_wdata;
            hsel          <= 1'b1;
            hwrite        <= pick_write;
            haddr         <= pick_addr;
            gnt[pick_idx] <= 1'b1;
          end
        end
        ADDR: begin
          state  <= DATA;
          cnt    <= '0;
          hsel   <= 1'b0;
          hwrite <= 1'b0;
          haddr  <= '0;
          hwdata <= lat_write ? lat_wdata : '0;
        end
        DATA: begin
          if (hready) begin
            state     <= IDLE;
            done[idx] <= 1'b1;
            err       <= hresp;
            rdata     <= lat_write ? '0 : hrdata;
            hwdata    <= '0;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            state     <= IDLE;
            done[idx] <= 1'b1;
            err       <= 1'b1;
            rdata     <= '0;
            hwdata    <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
